// File: rtl/simple_pic_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module  : simple_pic_dispatch_if
// Brief   : Wishbone master bus, vector handshake and control signals of the
//           PIC dispatcher. master = dispatcher side, slave = environment side.
// Revision: 1.0  initial release
// ============================================================================
interface simple_pic_dispatch_if #(
    parameter int VEC_W = 6
);
    logic             cyc_o;
    logic             stb_o;
    logic [31:0]      adr_o;
    logic             we_o;
    logic [3:0]       sel_o;
    logic [31:0]      dat_o;
    logic [31:0]      dat_i;
    logic             ack_i;
    logic             err_i;
    logic             en_i;
    logic             int_i;
    logic             vec_valid_o;
    logic [VEC_W-1:0] vec_o;
    logic             vec_ready_i;
    logic             bus_err_o;
    logic             err_clr_i;

    modport master (
        output cyc_o, stb_o, adr_o, we_o, sel_o, dat_o,
        output vec_valid_o, vec_o, bus_err_o,
        input  dat_i, ack_i, err_i, en_i, int_i, vec_ready_i, err_clr_i
    );

    modport slave (
        input  cyc_o, stb_o, adr_o, we_o, sel_o, dat_o,
        input  vec_valid_o, vec_o, bus_err_o,
        output dat_i, ack_i, err_i, en_i, int_i, vec_ready_i, err_clr_i
    );
endinterface
`default_nettype wire

// File: rtl/simple_pic_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : simple_pic_dispatch
// Brief   : Reads the PIC pending register, hands the lowest-numbered pending
//           IRQ to a local consumer, then clears it with a W1C write.
// Revision: 1.0  initial release
// ============================================================================
module simple_pic_dispatch #(
    parameter int          NUM_IRQ  = 32,
    parameter logic [31:0] PIC_BASE = 32'h0000_0000,
    parameter logic [1:0]  PEND_OFS = 2'd0,
    parameter int          VEC_W    = 6
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    simple_pic_dispatch_if.master bus
);

    localparam logic [31:0] C_PEND_ADR = PIC_BASE + {28'd0, PEND_OFS, 2'b00};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_SEL  = 3'd2,
        S_PRES = 3'd3,
        S_CLR  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_IRQ-1:0] r_pend;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   w_enc_vec;
    logic               r_bus_err;
    logic               w_bus_act;
    logic               w_wr;
    logic               w_err_evt;
    logic [31:0]        w_clr_mask;

    // Scan downward so the lowest set bit is the last one to overwrite.
    always_comb begin
        w_enc_vec = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (r_pend[k]) begin
                w_enc_vec = VEC_W'(k + 1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_evt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.en_i && bus.int_i) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (bus.err_i) begin
                    w_err_evt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (bus.ack_i) begin
                    w_state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                w_state_nxt = (r_pend == '0) ? S_IDLE : S_PRES;
            end
            S_PRES: begin
                if (bus.vec_ready_i) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                if (bus.err_i) begin
                    w_err_evt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (bus.ack_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_pend    <= '0;
            r_vec     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_RD && bus.ack_i && !bus.err_i) begin
                r_pend <= bus.dat_i[NUM_IRQ-1:0];
            end
            if (r_state == S_SEL && r_pend != '0) begin
                r_vec <= w_enc_vec;
            end
            // A fresh error outranks a simultaneous clear request.
            if (w_err_evt) begin
                r_bus_err <= 1'b1;
            end else if (bus.err_clr_i) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign w_bus_act  = (r_state == S_RD) || (r_state == S_CLR);
    assign w_wr       = (r_state == S_CLR);
    assign w_clr_mask = 32'd1 << (r_vec - VEC_W'(1));

    assign bus.cyc_o       = w_bus_act;
    assign bus.stb_o       = w_bus_act;
    assign bus.we_o        = w_wr;
    assign bus.sel_o       = w_bus_act ? 4'hF : 4'h0;
    assign bus.adr_o       = w_bus_act ? C_PEND_ADR : 32'h0;
    assign bus.dat_o       = w_wr ? w_clr_mask : 32'h0;
    assign bus.vec_valid_o = (r_state == S_PRES);
    assign bus.vec_o       = r_vec;
    assign bus.bus_err_o   = r_bus_err;

endmodule
`default_nettype wire
